// File: rtl/io_pkg.sv
// Shared definitions for the board-input side of the I/O path:
// debounce defaults, the switch word type and a counter-width helper.
package io_pkg;

  localparam int unsigned DEBOUNCE_TICK_DIV_DEFAULT = 50000;
  localparam int unsigned DEBOUNCE_STABLE_DEFAULT   = 4;
  localparam int unsigned SW_SYNC_STAGES_DEFAULT    = 2;

  typedef logic [31:0] sw_word_t;

  // Bits needed to hold 0..n-1; never returns a zero width.
  function automatic int unsigned min_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One conditioned switch bit: synchronizer chain, stability counter, level flop
// and, when SW_DEBOUNCE_EDGE_EN is defined, registered rise/fall pulses.
module sw_debounce_bit
  import io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = SW_SYNC_STAGES_DEFAULT,
  parameter int unsigned STABLE_TICKS = DEBOUNCE_STABLE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_raw_i,
  input  logic tick_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CW       = min_width(STABLE_TICKS + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw_i};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any cycle where the input agrees with the output restarts qualification.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (s == lvl_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign sw_o = lvl_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= lvl_d & ~lvl_q;
      fall_q <= ~lvl_d & lvl_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Switch/key input conditioner: shared sample-tick prescaler plus WIDTH
// independent debounce bits. Edge pulses exist only with SW_DEBOUNCE_EDGE_EN.
module sw_debounce
  import io_pkg::*;
#(
  parameter int unsigned WIDTH        = $bits(sw_word_t),
  parameter int unsigned SYNC_STAGES  = SW_SYNC_STAGES_DEFAULT,
  parameter int unsigned TICK_DIV     = DEBOUNCE_TICK_DIV_DEFAULT,
  parameter int unsigned STABLE_TICKS = DEBOUNCE_STABLE_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sw_raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] sw_rise_o,
  output logic [WIDTH-1:0] sw_fall_o
);

  localparam int unsigned   PW       = min_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  // With TICK_DIV = 1 the count is pinned at 0 and tick is permanently high.
  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pre_q <= '0;
    else         pre_q <= pre_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_bit (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .sw_raw_i (sw_raw_i[i]),
      .tick_i   (tick),
      .sw_o     (sw_o[i]),
      .rise_o   (sw_rise_o[i]),
      .fall_o   (sw_fall_o[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus random raw words, all checked
// cycle by cycle against a time-based reference of the debounce rules.
module tb_sw_debounce;

  localparam int W  = 32;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int SS = 2;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [W-1:0] raw;
  logic [W-1:0] sw, rise, fall;

  int n_checks = 0;
  int n_err    = 0;

  sw_debounce #(
    .WIDTH        (W),
    .SYNC_STAGES  (SS),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .sw_raw_i  (raw),
    .sw_o      (sw),
    .sw_rise_o (rise),
    .sw_fall_o (fall)
  );

  always #5 clk = ~clk;

  // Reference: raw history delayed by SS edges, a tick every TD-th edge since
  // reset release, and per bit the number of ticks seen while the settled
  // input has disagreed with the reported level without interruption.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_out, m_rise, m_fall;
  int           m_ticks_diff[W];
  int           m_edges;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k < SS; k++) m_hist.push_back('0);
    m_out = '0; m_rise = '0; m_fall = '0; m_edges = 0;
    for (int i = 0; i < W; i++) m_ticks_diff[i] = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] raw_at_edge);
    logic [W-1:0] settled;
    bit           tick_now;
    settled  = m_hist[0];
    tick_now = (m_edges % TD) == (TD - 1);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      if (settled[i] == m_out[i]) m_ticks_diff[i] = 0;
      else if (tick_now) begin
        m_ticks_diff[i] = m_ticks_diff[i] + 1;
        if (m_ticks_diff[i] == ST) begin
          m_out[i] = settled[i];
          m_ticks_diff[i] = 0;
          if (EDGE_ON) begin
            if (settled[i]) m_rise[i] = 1'b1;
            else            m_fall[i] = 1'b1;
          end
        end
      end
    end
    void'(m_hist.pop_front());
    m_hist.push_back(raw_at_edge);
    m_edges++;
  endtask

  // One clock: update the reference for this edge, then compare all outputs.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!rst_ni) model_reset();
    else         model_edge(raw);
    check("sw_o", sw, m_out);
    check("sw_rise_o", rise, m_rise);
    check("sw_fall_o", fall, m_fall);
  endtask

  task automatic pulse_reset(input int n);
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("rst_async_sw", sw, '0);
    check("rst_async_edges", rise | fall, '0);
    for (int k = 0; k < n; k++) cycle();
    rst_ni = 1'b1;
  endtask

  initial begin
    int first, rises, falls, trans, lat;
    logic prev;
    logic [W-1:0] snap_sw, snap_edge;

    // Reset with all raw bits high, then release with raw low.
    raw    = '1;
    rst_ni = 1'b0;
    model_reset();
    #2;
    check("reset_sw", sw, '0);
    check("reset_rise", rise, '0);
    check("reset_fall", fall, '0);
    for (int k = 0; k < 5; k++) cycle();
    raw    = '0;
    rst_ni = 1'b1;
    for (int k = 0; k < 50; k++) cycle();
    check("idle_after_reset", sw, '0);

    // Clean press on bit 0.
    raw[0] = 1'b1;
    first = 0; rises = 0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (first == 0 && sw[0]) begin
        first = c;
        check("press_rise_same_cycle", rise[0], EDGE_ON);
      end
      rises += int'(rise[0]);
    end
    check("press_latency_in_window", (first >= 11 && first <= 14), 1);
    check("press_rise_count", rises, EDGE_ON ? 1 : 0);
    check("press_other_bits", sw[W-1:1], '0);

    // Bit 5 bounces with 3-cycle pulses, then settles high.
    trans = 0; rises = 0; falls = 0; lat = 0;
    prev = sw[5];
    for (int c = 0; c < 40; c++) begin
      raw[5] = ((c / 3) % 2) == 0;
      cycle();
      if (sw[5] != prev) trans++;
      prev = sw[5];
      rises += int'(rise[5]);
      falls += int'(fall[5]);
    end
    raw[5] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (sw[5] != prev) begin
        trans++;
        if (lat == 0) lat = c;
      end
      prev = sw[5];
      rises += int'(rise[5]);
      falls += int'(fall[5]);
    end
    check("bounce_transitions", trans, 1);
    check("bounce_settle_latency", (lat >= 1 && lat <= 14), 1);
    check("bounce_rise_count", rises, EDGE_ON ? 1 : 0);
    check("bounce_fall_count", falls, 0);

    // Two bits change together, then release together.
    raw = '0;
    for (int k = 0; k < 20; k++) cycle();
    check("cleared", sw, '0);
    raw = 32'h0003_0000;
    first = 0; snap_sw = '0; snap_edge = '0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (first == 0 && (sw & 32'h0003_0000) != 0) begin
        first = c; snap_sw = sw; snap_edge = rise;
      end
    end
    check("simul_rise_level", snap_sw, 32'h0003_0000);
    check("simul_rise_pulse", snap_edge, EDGE_ON ? 32'h0003_0000 : 32'h0);
    raw = '0;
    first = 0; snap_sw = '1; snap_edge = '0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (first == 0 && (sw & 32'h0003_0000) != 32'h0003_0000) begin
        first = c; snap_sw = sw; snap_edge = fall;
      end
    end
    check("simul_fall_level", snap_sw, 32'h0);
    check("simul_fall_pulse", snap_edge, EDGE_ON ? 32'h0003_0000 : 32'h0);

    // Reset in the middle of qualifying bit 2.
    raw[2] = 1'b1;
    for (int k = 0; k < 8; k++) cycle();
    check("midcount_not_yet", sw[2], 1'b0);
    pulse_reset(3);
    check("midcount_through_reset", sw[2], 1'b0);
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (first == 0 && sw[2]) first = c;
    end
    check("midcount_full_latency", (first >= 11 && first <= 14), 1);

    // Random words with random hold times, including sub-tick glitches.
    for (int seg = 0; seg < 80; seg++) begin
      raw = $urandom();
      for (int k = 0; k < int'($urandom_range(1, 16)); k++) cycle();
      if (seg == 40) pulse_reset(int'($urandom_range(1, 4)));
    end
    for (int k = 0; k < 20; k++) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
